// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory port arbiter: bus widths, FSM states and port ids.
package cpu_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  // Port ids double as bit positions in the two-bit request/grant vectors.
  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } port_id_t;

  // The port that did not win; used to hand a conflict to the other side.
  function automatic port_id_t other_port(input port_id_t p);
    return (p == FETCH) ? DATA : FETCH;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. A lone requester always wins; on a conflict
// the port that was not granted last wins. The history bit only advances on an
// actual grant, which happens only while en is high.
module rr_arbiter2
  import cpu_mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic [1:0] req,
  output logic     valid,
  output logic [1:0] gnt_oh,
  output port_id_t winner
);

  port_id_t last_grant_q;
  port_id_t last_grant_d;

  // Pick the winner and compute the next history value.
  always_comb begin
    winner = FETCH;
    if (req[DATA] && req[FETCH]) begin
      winner = other_port(last_grant_q);
    end else if (req[DATA]) begin
      winner = DATA;
    end
    valid  = en && (req != 2'b00);
    gnt_oh = 2'b00;
    if (valid) begin
      gnt_oh[winner] = 1'b1;
    end
    last_grant_d = valid ? winner : last_grant_q;
  end

  // History resets to FETCH so the data port wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= FETCH;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage.
// One access at a time: IDLE arbitrates and latches the winner, READ holds
// r_flag for MEM_LAT cycles and captures the data, RESP pulses rvalid, WRITE
// holds w_flag for a single cycle. Every output comes straight from a flop.
module mem_port_arbiter #(
  parameter int ADDR_W  = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W  = cpu_mem_pkg::DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_r_flag,
  output logic              mem_w_flag,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  import cpu_mem_pkg::*;

  // Final value of the 3-bit latency counter; MEM_LAT is limited to 1..8.
  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  mem_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  port_id_t          port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              r_flag_q, r_flag_d;
  logic              w_flag_q, w_flag_d;
  logic              if_gnt_q, if_gnt_d;
  logic              dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;

  logic              arb_valid;
  logic [1:0]        arb_gnt_oh;
  port_id_t          arb_winner;

  // Requests are only looked at while idle; anything else is ignored.
  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == IDLE),
    .req    ({dm_req, if_req}),
    .valid  (arb_valid),
    .gnt_oh (arb_gnt_oh),
    .winner (arb_winner)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    r_flag_d    = 1'b0;
    w_flag_d    = 1'b0;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          port_d   = arb_winner;
          cnt_d    = 3'd0;
          if_gnt_d = arb_gnt_oh[FETCH];
          dm_gnt_d = arb_gnt_oh[DATA];
          if (arb_winner == DATA) begin
            addr_d = dm_addr;
            if (dm_we) begin
              wdata_d  = dm_wdata;
              w_flag_d = 1'b1;
              state_d  = WRITE;
            end else begin
              r_flag_d = 1'b1;
              state_d  = READ;
            end
          end else begin
            addr_d   = if_addr;
            r_flag_d = 1'b1;
            state_d  = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == LAST_CNT) begin
          // Last cycle of the read window: sample memory into the owner's register.
          if (port_q == FETCH) begin
            if_rdata_d  = mem_read_data;
            if_rvalid_d = 1'b1;
          end else begin
            dm_rdata_d  = mem_read_data;
            dm_rvalid_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d    = cnt_q + 3'd1;
          r_flag_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops the memory flags at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      port_q      <= FETCH;
      addr_q      <= '0;
      wdata_q     <= '0;
      r_flag_q    <= 1'b0;
      w_flag_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      r_flag_q    <= r_flag_d;
      w_flag_q    <= w_flag_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt         = if_gnt_q;
  assign if_rvalid      = if_rvalid_q;
  assign if_rdata       = if_rdata_q;
  assign dm_gnt         = dm_gnt_q;
  assign dm_rvalid      = dm_rvalid_q;
  assign dm_rdata       = dm_rdata_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_r_flag     = r_flag_q;
  assign mem_w_flag     = w_flag_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing checks, a MEM_LAT=3 instance,
// and randomized request rounds checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance signals
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr, mem_address;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_write_data, mem_read_data;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_r_flag, mem_w_flag, busy;

  // MEM_LAT=3 instance signals
  logic          if_req3, dm_req3, dm_we3;
  logic [AW-1:0] if_addr3, dm_addr3, mem_address3;
  logic [DW-1:0] dm_wdata3, if_rdata3, dm_rdata3, mem_write_data3, mem_read_data3;
  logic          if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_r_flag3, mem_w_flag3, busy3;

  // Memory model: combinational read, write on the clock edge.
  logic [DW-1:0] mem_arr [0:65535];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem_arr[pre_addr] <= pre_data;
    else if (mem_w_flag) mem_arr[mem_address] <= mem_write_data;
  end
  assign mem_read_data  = mem_arr[mem_address];
  assign mem_read_data3 = mem_arr[mem_address3];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_r_flag(mem_r_flag), .mem_w_flag(mem_w_flag), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_we(dm_we3), .dm_addr(dm_addr3), .dm_wdata(dm_wdata3),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_address(mem_address3), .mem_write_data(mem_write_data3),
    .mem_r_flag(mem_r_flag3), .mem_w_flag(mem_w_flag3), .mem_read_data(mem_read_data3),
    .busy(busy3)
  );

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] ref_mem [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    int          mode;
    logic [5:0]  v_rf, v_rv, v_g;
    logic [1:0]  exp_g;
    logic        if_pend, dm_pend, if_out, dm_out, pi, pd, done;
    logic        last_port;   // 0 = fetch, 1 = data
    logic [DW-1:0] exp_if, exp_dm;

    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 0; dm_req3 = 0; dm_we3 = 0; if_addr3 = '0; dm_addr3 = '0; dm_wdata3 = '0;
    pre_we = 0; pre_addr = '0; pre_data = '0;
    rst_n = 0;

    // Preload memory words 0..15 while reset is held.
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'($urandom);
    ref_mem[4] = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      pre_we = 1; pre_addr = 16'(i); pre_data = ref_mem[i];
      step();
    end
    pre_we = 0;

    // Reset state
    chk("rst_flags", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_r_flag, mem_w_flag, busy}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("rst_bus", {mem_address, mem_write_data}, 0);
    chk("rst_busy3", {busy3, mem_r_flag3, if_gnt3}, 0);
    rst_n = 1;
    step();

    // Lone fetch
    if_req = 1; if_addr = 16'h0004;
    step();
    chk("lf_c1_gnt", {if_gnt, dm_gnt}, 2'b10);
    chk("lf_c1_rflag", {mem_r_flag, mem_w_flag}, 2'b10);
    chk("lf_c1_addr", mem_address, 16'h0004);
    chk("lf_c1_busy", busy, 1);
    if_req = 0;
    step();
    chk("lf_c2_rvalid", if_rvalid, 1);
    chk("lf_c2_rdata", if_rdata, 16'h1234);
    chk("lf_c2_misc", {if_gnt, mem_r_flag, busy}, 3'b001);
    step();
    chk("lf_c3_idle", {if_rvalid, busy}, 0);

    // Store then load of the same address
    dm_req = 1; dm_we = 1; dm_addr = 16'h000A; dm_wdata = 16'hFFFE;
    step();
    chk("st_c1_gnt", dm_gnt, 1);
    chk("st_c1_flags", {mem_w_flag, mem_r_flag}, 2'b10);
    chk("st_c1_bus", {mem_address, mem_write_data}, {16'h000A, 16'hFFFE});
    dm_req = 0; ref_mem[10] = 16'hFFFE;
    step();
    chk("st_c2", {mem_w_flag, dm_rvalid, busy}, 0);
    step();
    chk("st_c3_norvalid", dm_rvalid, 0);
    dm_req = 1; dm_we = 0; dm_addr = 16'h000A;
    step();
    chk("ld_c1_gnt", {dm_gnt, mem_r_flag}, 2'b11);
    dm_req = 0;
    step();
    chk("ld_c2_rvalid", dm_rvalid, 1);
    chk("ld_c2_rdata", dm_rdata, 16'hFFFE);
    chk("ld_c2_if_rdata_held", if_rdata, 16'h1234);
    step();

    // Reset in the middle of a read
    if_req = 1; if_addr = 16'h0004;
    step();
    chk("rmr_c1_rflag", mem_r_flag, 1);
    if_req = 0;
    #3 rst_n = 0;
    #1;
    chk("rmr_async_flags", {mem_r_flag, mem_w_flag, busy}, 0);
    step();
    step();
    rst_n = 1;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n += int'(if_rvalid) + int'(if_gnt);
    end
    chk("rmr_no_resp", n, 0);

    // Both ports held after reset: DATA, FETCH, DATA, FETCH every 3 cycles
    if_req = 1; if_addr = 16'h0004; dm_req = 1; dm_we = 0; dm_addr = 16'h000A;
    for (int c = 1; c <= 11; c++) begin
      step();
      exp_g = 2'b00;
      if ((c - 1) % 3 == 0) exp_g = (((c - 1) / 3) % 2 == 0) ? 2'b10 : 2'b01;
      chk($sformatf("sim_gnt_c%0d", c), {dm_gnt, if_gnt}, exp_g);
    end
    if_req = 0; dm_req = 0;
    step();
    step();

    // Fetch request pulsed while a store is in progress is ignored
    dm_req = 1; dm_we = 1; dm_addr = 16'h0005; dm_wdata = 16'($urandom);
    step();
    chk("wd_c1_gnt", dm_gnt, 1);
    dm_req = 0; ref_mem[5] = dm_wdata;
    if_req = 1; if_addr = 16'h0003;
    step();
    if_req = 0;
    n = int'(if_gnt) + int'(mem_r_flag);
    for (int c = 0; c < 4; c++) begin
      step();
      n += int'(if_gnt) + int'(mem_r_flag);
    end
    chk("wd_no_fetch", n, 0);
    last_port = 1'b1;   // that store was the most recent grant

    // MEM_LAT=3 read on the second instance, request held after grant
    if_req3 = 1; if_addr3 = 16'h0004;
    v_rf = '0; v_rv = '0; v_g = '0;
    for (int c = 1; c <= 6; c++) begin
      step();
      v_rf[c-1] = mem_r_flag3;
      v_rv[c-1] = if_rvalid3;
      v_g[c-1]  = if_gnt3;
      if (c == 4) chk("l3_rdata", if_rdata3, 16'h1234);
      if (c == 6) if_req3 = 0;
    end
    chk("l3_rflag_seq", v_rf, 6'b100111);
    chk("l3_rvalid_seq", v_rv, 6'b001000);
    chk("l3_gnt_seq", v_g, 6'b100001);
    for (int c = 0; c < 5; c++) step();

    // Randomized rounds against a transaction-level model
    if_out = 0; dm_out = 0; exp_if = '0; exp_dm = '0;
    for (int r = 0; r < 60; r++) begin
      if_pend = 0; dm_pend = 0;
      mode = int'($urandom_range(0, 2));
      if (mode != 1) begin
        if_req = 1; if_addr = 16'($urandom_range(0, 15)); if_pend = 1;
      end
      if (mode != 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 15)); dm_wdata = 16'($urandom); dm_pend = 1;
      end
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        step();
        chk("excl", {if_gnt & dm_gnt, mem_r_flag & mem_w_flag}, 0);
        pi = if_pend; pd = dm_pend;
        if (if_gnt) begin
          chk("rnd_if_gnt_req", pi, 1);
          if (pd) chk("rnd_rr_fetch", last_port, 1'b1);
          chk("rnd_if_bus", {mem_r_flag, mem_address}, {1'b1, if_addr});
          last_port = 1'b0; if_pend = 0; if_req = 0; if_out = 1;
          exp_if = ref_mem[if_addr[3:0]];
        end
        if (dm_gnt) begin
          chk("rnd_dm_gnt_req", pd, 1);
          if (pi) chk("rnd_rr_data", last_port, 1'b0);
          last_port = 1'b1; dm_pend = 0; dm_req = 0;
          if (dm_we) begin
            chk("rnd_st_bus", {mem_w_flag, mem_address, mem_write_data}, {1'b1, dm_addr, dm_wdata});
            ref_mem[dm_addr[3:0]] = dm_wdata;
          end else begin
            chk("rnd_ld_bus", {mem_r_flag, mem_address}, {1'b1, dm_addr});
            dm_out = 1; exp_dm = ref_mem[dm_addr[3:0]];
          end
        end
        if (if_rvalid) begin
          chk("rnd_if_rvalid_expected", if_out, 1);
          chk("rnd_if_rdata", if_rdata, exp_if);
          if_out = 0;
        end
        if (dm_rvalid) begin
          chk("rnd_dm_rvalid_expected", dm_out, 1);
          chk("rnd_dm_rdata", dm_rdata, exp_dm);
          dm_out = 0;
        end
        done = !if_pend && !dm_pend && !if_out && !dm_out;
      end
      chk("rnd_round_done", done, 1);
      if (!done) begin
        if_req = 0; dm_req = 0; if_pend = 0; dm_pend = 0; if_out = 0; dm_out = 0;
        for (int c = 0; c < 12; c++) step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-ported 16-bit data/instruction `Memory` between the instruction-fetch unit and the load/store (data-memory) stage. It takes requests on two req/gnt ports and arbitrates them round-robin. It drives the memory's `address`, `write_data`, `r_flag` and `w_flag` for exactly one access at a time, and returns registered read data with a one-cycle valid pulse. It sits between the pipeline front/back ends and the `Memory` instance in the processor top level.

## Interface
- `ADDR_W`, 16: memory address width (word addressed).
- `DATA_W`, 16: data width (signed data passed through unchanged).
- `MEM_LAT`, 1: cycles `r_flag` is held before `read_data` is sampled; legal range is 1..8.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `if_req`  in  1: fetch read request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  ADDR_W: fetch address.
- `if_gnt`  out  1: one-cycle grant pulse; fetch request accepted.
- `if_rvalid`  out  1: one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DATA_W: fetch read data.
- `dm_req`  in  1: data request; held with `dm_we`, `dm_addr`, `dm_wdata` until `dm_gnt`.
- `dm_we`  in  1: 1 = store, 0 = load.
- `dm_addr`  in  ADDR_W: data address.
- `dm_wdata`  in  DATA_W: store data.
- `dm_gnt`  out  1: one-cycle grant pulse.
- `dm_rvalid`  out  1: one-cycle pulse, loads only.
- `dm_rdata`  out  DATA_W: load data.
- `mem_address`  out  ADDR_W: to `Memory.address`.
- `mem_write_data`  out  DATA_W: to `Memory.write_data`.
- `mem_r_flag`  out  1: to `Memory.r_flag`.
- `mem_w_flag`  out  1: to `Memory.w_flag`.
- `mem_read_data`  in  DATA_W: from `Memory.read_data`.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- **FSM states:** IDLE, READ, WRITE, RESP.
- **IDLE:**
  - If no request is present, stay in IDLE.
  - If any request is present, arbitrate, latch the winner's fields into registers, and go to READ (fetch, or data with `dm_we=0`) or WRITE (data with `dm_we=1`).
- **Arbitration:**
  - A lone requester wins.
  - On conflict, the port not granted last wins.
  - `last_grant` resets to FETCH, so the data port wins the first conflict after reset.
  - `last_grant` updates on every grant.
- **READ:**
  - `mem_r_flag`=1 and `mem_address` is held for MEM_LAT cycles, counted by a 3-bit counter.
  - On the last cycle, `mem_read_data` is captured into the winner's rdata register, then the FSM goes to RESP.
- **WRITE:** `mem_w_flag`=1 for exactly one cycle with `mem_address`/`mem_write_data` held, then the FSM goes to IDLE. There is no rvalid for a write.
- **RESP:** the winner's rvalid pulses for one cycle, then the FSM goes to IDLE.
- **Data path:** addresses and data pass unmodified; there is no sign or width conversion.
- **Mutual exclusion:** `mem_r_flag` and `mem_w_flag` are never high in the same cycle.
- **Held outputs:** the rdata outputs hold their last captured value until the next read completes for that port.
- **Request withdrawal:** a request dropped before its grant is legal and is ignored. Requests and fields that change while the block is not in IDLE are not sampled.

## Timing
- **Registered outputs:** all outputs are registered.
- **Grant cycle:** a request seen in IDLE in cycle 0 gives gnt high in cycle 1, with flags/address driven from cycle 1.
- **Read:** rvalid and rdata appear in cycle MEM_LAT+1. With MEM_LAT=1, reads issue at most one per 3 cycles.
- **Write:** `w_flag` is high in cycle 1 only, and the FSM is back in IDLE in cycle 2. Writes issue at most one per 2 cycles.
- **Re-request:** a requester holding req after its gnt cycle is treated as a new request. Requesters must drop req in the gnt cycle to avoid a duplicate access.
- **Reset values:** all outputs reset to 0, state to IDLE, counter to 0, `last_grant` to FETCH.
- **Reset mid-access:** `mem_r_flag`/`mem_w_flag` drop immediately (asynchronous), and no rvalid or gnt is issued for the aborted access.

## Structure
- **Shared package `cpu_mem_pkg`:** `ADDR_W`/`DATA_W` constants, the `mem_state_t` enum (IDLE/READ/WRITE/RESP), and the `port_id_t` enum (FETCH/DATA).
- **Sub-module `rr_arbiter2`:** two-request round-robin arbiter with `last_grant` state, plus enable and grant-one-hot outputs.
- The `Memory` instance lives in the top level, not inside this block.

## Test plan
- **Lone fetch:** `if_req`, `if_addr`=0x0004, memory[4]=0x1234, MEM_LAT=1 -> `if_gnt` in cycle 1, `mem_r_flag` cycle 1, `if_rvalid` cycle 2 with `if_rdata`=0x1234, `busy` cycles 1–2.
- **Store then load:** store `dm_addr`=0x000A, `dm_wdata`=0xFFFE -> `mem_w_flag` for exactly 1 cycle and no `dm_rvalid`. A following load of 0x000A -> `dm_rdata`=0xFFFE (-2).
- **Simultaneous requests after reset:** both ports request and are held -> DATA is granted first, then FETCH, then DATA, strictly alternating.
- **MEM_LAT=3 read:** `r_flag` high for 3 consecutive cycles, rvalid in cycle 4, and no new grant before cycle 5.
- **Reset mid-read:** `rst_n` is driven low during READ -> flags go to 0 within the same cycle, no rvalid follows, and the first post-reset request is granted normally.
- **Request withdrawal:** `if_req` pulses for 1 cycle while the block is busy with a store -> no fetch access and no `if_gnt` occurs.
